// File: rtl/header_creator_pkg.sv
// Shared types and constants for the N3/N6 GTP-U header blocks.
package header_creator_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned KEEP_W = 8;
    localparam int unsigned HALF_W = 32;
    localparam int unsigned CNT_W  = 32;

    localparam logic [7:0]  IPV4_VER_IHL      = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP      = 8'd17;
    localparam logic [15:0] GTPU_UDP_PORT     = 16'd2152;
    localparam logic [7:0]  GTPU_MSG_GPDU     = 8'hFF;
    localparam logic [7:0]  GTPU_EXT_PDU_SESS = 8'h85;

    typedef enum logic [2:0] {
        N6_IDLE,
        N6_HDR,
        N6_FWD,
        N6_FLUSH,
        N6_DROP
    } HC_N6_STATES;

    // Descriptor handed to the N6 egress scheduler alongside each packet.
    typedef struct packed {
        logic [7:0]  int_gate;
        logic [31:0] GTPU_TEID;
        logic [7:0]  QFI;
        logic [15:0] Q_ID;
    } ADS_N6;

endpackage

// File: rtl/gtpu_byte_realign.sv
// Four-byte realignment stage for the N6 stripper.
// Keeps the low half of the previous input beat in a hold register and emits
// {hold, in[63:32]} as the output beat; a flush emits the hold bytes alone.
// Ports: in_* = accepted input beat; hold_load primes hold from the last header
// beat; beat_push / flush_push load the output register; m_* = AXI-stream
// master side; out_free_c = output register can take a new beat this cycle.
module gtpu_byte_realign
    import header_creator_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_last,
    input  logic              hold_load,
    input  logic              beat_push,
    input  logic              flush_push,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tvalid,
    output logic              m_tlast,
    output logic              m_sop,
    output logic              out_free_c
);

    logic [HALF_W-1:0] hold;
    logic [3:0]        hold_keep;
    logic              first;

    assign out_free_c = !m_tvalid || m_tready;

    // Output register plus hold; a last beat with more than four bytes leaves
    // a residual in hold that the flush beat carries with tlast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold      <= '0;
            hold_keep <= '0;
            first     <= 1'b0;
            m_tdata   <= '0;
            m_tkeep   <= '0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            m_sop     <= 1'b0;
        end else begin
            if (beat_push) begin
                m_tdata   <= {hold, in_data[DATA_W-1:HALF_W]};
                m_tkeep   <= {4'hF, in_keep[7:4]};
                m_tlast   <= in_last && !in_keep[3];
                m_sop     <= first;
                m_tvalid  <= 1'b1;
                first     <= 1'b0;
                hold      <= in_data[HALF_W-1:0];
                hold_keep <= in_keep[3:0];
            end else if (flush_push) begin
                m_tdata  <= {hold, 32'h0};
                m_tkeep  <= {hold_keep, 4'h0};
                m_tlast  <= 1'b1;
                m_sop    <= first;
                m_tvalid <= 1'b1;
                first    <= 1'b0;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end

            if (hold_load) begin
                hold      <= in_data[HALF_W-1:0];
                hold_keep <= in_keep[3:0];
                first     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gtpu_header_stripper.sv
// N3->N6 decapsulator: validates and removes the 36B/44B IPv4/UDP/GTP-U outer
// header, forwards the inner packet realigned to byte 0, and publishes an
// ADS_N6 descriptor for the packet.
// Ports: s_* = N3 input stream (byte0 = tdata[63:56]); m_* = inner packet
// stream; m_sop marks the first output beat; m_meta = descriptor, stable for the
// whole output packet; pkt_ok_cnt / drop_cnt = wrapping packet counters.
module gtpu_header_stripper
    import header_creator_pkg::*;
#(
    parameter logic [7:0]  PORT_ID  = 8'h06,
    parameter logic [15:0] QID_BASE = 16'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [KEEP_W-1:0] s_tkeep,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready,
    output logic              m_sop,
    output logic [DATA_W-1:0] m_meta,
    output logic [CNT_W-1:0]  pkt_ok_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    HC_N6_STATES state;
    logic [2:0]  hdr_idx;
    logic        ext;
    logic [31:0] teid;
    logic        flush_pend;
    ADS_N6       meta_q;

    logic        out_free_c;
    logic        s_fire_c;
    logic        beat_err_c;
    logic        last_hdr_c;
    logic        hdr_ok_c;
    logic        hdr_drop_c;
    logic [5:0]  qfi_c;
    logic [31:0] teid_c;

    assign m_meta   = meta_q;
    assign s_tready = (state == N6_HDR) || (state == N6_DROP) ||
                      ((state == N6_FWD) && out_free_c);
    assign s_fire_c = s_tvalid && s_tready;

    // Per-beat header checks; the inner packet always starts at byte 4 of the
    // last header beat (beat 4, or beat 5 when the extension header is present).
    always_comb begin
        beat_err_c = 1'b0;
        last_hdr_c = 1'b0;
        case (hdr_idx)
            3'd0: beat_err_c = (s_tdata[63:56] != IPV4_VER_IHL);
            3'd1: beat_err_c = (s_tdata[55:48] != IP_PROTO_UDP);
            3'd2: beat_err_c = (s_tdata[15:0] != GTPU_UDP_PORT);
            3'd3: beat_err_c = (s_tdata[31:29] != 3'b001) || !s_tdata[28] ||
                               (s_tdata[23:16] != GTPU_MSG_GPDU) ||
                               ((s_tdata[26:24] != 3'b000) && !s_tdata[26]);
            3'd4: begin
                last_hdr_c = !ext;
                beat_err_c = ext && (s_tdata[7:0] != GTPU_EXT_PDU_SESS);
            end
            3'd5: begin
                last_hdr_c = 1'b1;
                beat_err_c = (s_tdata[63:56] != 8'h01) || (s_tdata[39:32] != 8'h00);
            end
            default: ;
        endcase
    end

    // A header ending on tlast is kept only if at least one inner byte follows it.
    assign hdr_ok_c   = (state == N6_HDR) && s_fire_c && last_hdr_c && !beat_err_c &&
                        (!s_tlast || s_tkeep[3]);
    assign hdr_drop_c = (state == N6_HDR) && s_fire_c && !hdr_ok_c &&
                        (beat_err_c || s_tlast);
    assign qfi_c      = (hdr_idx == 3'd5) ? s_tdata[45:40] : 6'd0;
    assign teid_c     = (hdr_idx == 3'd4) ? s_tdata[63:32] : teid;

    // Packet-level control FSM and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= N6_IDLE;
            hdr_idx    <= '0;
            ext        <= 1'b0;
            teid       <= '0;
            flush_pend <= 1'b0;
            meta_q     <= '0;
            pkt_ok_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            case (state)
                N6_IDLE: begin
                    if (s_tvalid) begin
                        state   <= N6_HDR;
                        hdr_idx <= '0;
                        ext     <= 1'b0;
                    end
                end
                N6_HDR: begin
                    if (s_fire_c) begin
                        hdr_idx <= hdr_idx + 3'd1;
                        if (hdr_idx == 3'd3) ext  <= s_tdata[26];
                        if (hdr_idx == 3'd4) teid <= s_tdata[63:32];
                        if (hdr_drop_c) begin
                            drop_cnt <= drop_cnt + 32'd1;
                            state    <= s_tlast ? N6_IDLE : N6_DROP;
                        end else if (hdr_ok_c) begin
                            meta_q.int_gate  <= PORT_ID;
                            meta_q.GTPU_TEID <= teid_c;
                            meta_q.QFI       <= {2'b00, qfi_c};
                            meta_q.Q_ID      <= QID_BASE + {10'd0, qfi_c};
                            if (s_tlast) begin
                                state      <= N6_FLUSH;
                                flush_pend <= 1'b1;
                            end else begin
                                state <= N6_FWD;
                            end
                        end
                    end
                end
                N6_FWD: begin
                    if (s_fire_c && s_tlast) begin
                        state      <= N6_FLUSH;
                        flush_pend <= s_tkeep[3];
                    end
                end
                N6_FLUSH: begin
                    // Emit any residual, then leave once the tlast beat is taken.
                    if (flush_pend) begin
                        if (out_free_c) flush_pend <= 1'b0;
                    end else if (m_tvalid && m_tready && m_tlast) begin
                        state      <= N6_IDLE;
                        pkt_ok_cnt <= pkt_ok_cnt + 32'd1;
                    end
                end
                N6_DROP: begin
                    if (s_fire_c && s_tlast) state <= N6_IDLE;
                end
                default: state <= N6_IDLE;
            endcase
        end
    end

    gtpu_byte_realign u_realign (
        .clk        (clk),
        .rst        (rst),
        .in_data    (s_tdata),
        .in_keep    (s_tkeep),
        .in_last    (s_tlast),
        .hold_load  (hdr_ok_c),
        .beat_push  ((state == N6_FWD) && s_fire_c),
        .flush_push ((state == N6_FLUSH) && flush_pend && out_free_c),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_sop      (m_sop),
        .out_free_c (out_free_c)
    );

endmodule

// File: tb/tb_gtpu_header_stripper.sv
// Scoreboard bench for gtpu_header_stripper: a byte-level reference model turns
// each generated N3 packet into expected output beats and counter updates.
module tb_gtpu_header_stripper;
    import header_creator_pkg::*;

    localparam logic [7:0]  PORT_ID  = 8'h06;
    localparam logic [15:0] QID_BASE = 16'h0100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic        m_sop;
    logic [63:0] m_meta;
    logic [31:0] pkt_ok_cnt;
    logic [31:0] drop_cnt;

    gtpu_header_stripper #(.PORT_ID(PORT_ID), .QID_BASE(QID_BASE)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready), .m_sop(m_sop), .m_meta(m_meta),
        .pkt_ok_cnt(pkt_ok_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        sop;
        logic [63:0] meta;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ok_exp = 0;
    int   drop_exp = 0;
    bit   mon_en = 1'b1;
    bit   rdy_rand = 1'b0;
    bit   gap_en = 1'b0;

    function automatic logic [63:0] kmask(input logic [7:0] k);
        logic [63:0] m = '0;
        for (int j = 0; j < 8; j++) m[63-8*j -: 8] = {8{k[7-j]}};
        return m;
    endfunction

    // Builds an N3 packet; corrupt selects one header fault (0 = none, 10 = truncate).
    function automatic bq_t build_pkt(input bit ext, input int inner_len, input logic [31:0] teid,
                                      input logic [5:0] qfi, input int corrupt);
        bq_t p;
        int hl = ext ? 44 : 36;
        int tot = hl + inner_len;
        logic [15:0] ln = 16'(tot - 36);
        for (int i = 0; i < tot; i++) p.push_back(8'($urandom));
        p[0] = 8'h45; p[9] = 8'd17; p[22] = 8'h08; p[23] = 8'h68;
        p[28] = ext ? 8'h34 : 8'h30; p[29] = 8'hFF; p[30] = ln[15:8]; p[31] = ln[7:0];
        p[32] = teid[31:24]; p[33] = teid[23:16]; p[34] = teid[15:8]; p[35] = teid[7:0];
        if (ext) begin
            p[39] = 8'h85; p[40] = 8'h01; p[42] = {2'($urandom), qfi}; p[43] = 8'h00;
        end
        case (corrupt)
            1: p[23] = 8'h69;
            2: p[29] = 8'h01;
            3: p[28] = 8'h32;
            4: p[0]  = 8'h46;
            5: p[9]  = 8'd6;
            6: p[28] = p[28] ^ 8'h40;
            7: if (p.size() > 39) p[39] = 8'h84;
            8: if (p.size() > 40) p[40] = 8'h02;
            9: if (p.size() > 43) p[43] = 8'h01;
            10: begin
                int l = $urandom_range(1, hl);
                while (p.size() > l) void'(p.pop_back());
            end
            default: ;
        endcase
        return p;
    endfunction

    // Reference model: decide from the packet bytes, queue the inner bytes in 8-byte beats.
    function automatic void model(input bq_t p);
        int n = p.size();
        bit ok = 1'b1;
        int hl = 36;
        logic [5:0]  qfi = '0;
        logic [31:0] teid;
        logic [63:0] meta;
        if (n < 30) ok = 1'b0;
        else begin
            hl = p[28][2] ? 44 : 36;
            if (n <= hl) ok = 1'b0;
            else begin
                if (p[0] != 8'h45) ok = 1'b0;
                if (p[9] != 8'd17) ok = 1'b0;
                if ({p[22], p[23]} != 16'd2152) ok = 1'b0;
                if (p[28][7:5] != 3'd1 || p[28][4] != 1'b1) ok = 1'b0;
                if (p[29] != 8'hFF) ok = 1'b0;
                if (p[28][2:0] != 3'd0 && !p[28][2]) ok = 1'b0;
                if (p[28][2]) begin
                    if (p[39] != 8'h85 || p[40] != 8'h01 || p[43] != 8'h00) ok = 1'b0;
                    qfi = p[42][5:0];
                end
            end
        end
        if (!ok) begin
            drop_exp++;
            return;
        end
        teid = {p[32], p[33], p[34], p[35]};
        meta = {PORT_ID, teid, 2'b00, qfi, 16'(QID_BASE + 16'(qfi))};
        for (int b = hl; b < n; b += 8) begin
            exp_t e;
            e.data = '0; e.keep = '0;
            for (int j = 0; j < 8; j++)
                if (b + j < n) begin
                    e.data[63-8*j -: 8] = p[b+j];
                    e.keep[7-j] = 1'b1;
                end
            e.last = (b + 8 >= n);
            e.sop  = (b == hl);
            e.meta = meta;
            exp_q.push_back(e);
        end
        ok_exp++;
    endfunction

    // Drives a byte queue as beats; called and returns at posedge+1.
    task automatic send_bytes(input bq_t p, input bit mark_last);
        int n = p.size();
        int nb = (n + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            logic [63:0] d = '0;
            logic [7:0]  k = '0;
            bit acc = 1'b0;
            int t = 0;
            for (int j = 0; j < 8; j++)
                if (b * 8 + j < n) begin
                    d[63-8*j -: 8] = p[b*8+j];
                    k[7-j] = 1'b1;
                end
            if (gap_en) repeat ($urandom_range(0, 2)) begin
                s_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            s_tdata = d; s_tkeep = k; s_tlast = mark_last && (b == nb - 1); s_tvalid = 1'b1;
            while (!acc) begin
                @(negedge clk); acc = s_tready;
                @(posedge clk); #1;
                t++;
                if (t > 5000) begin
                    checks++; errors++;
                    $display("FAIL input_accept_timeout: beat %0d not accepted, required s_tready=1", b);
                    s_tvalid = 1'b0;
                    return;
                end
            end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic issue(input bq_t p);
        model(p);
        send_bytes(p, 1'b1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(posedge clk); t++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_counts(input string tag);
        @(negedge clk);
        chk({tag, "_ok_cnt"}, 64'(pkt_ok_cnt), 64'(ok_exp));
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(drop_exp));
        @(posedge clk); #1;
    endtask

    // Sink readiness, optionally randomised.
    always @(posedge clk) begin
        #1;
        m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: compares every output handshake and checks hold-stability under backpressure.
    exp_t        mon_e;
    bit          stalled = 1'b0;
    logic [138:0] st_vec;
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if ({m_tvalid, m_tdata, m_tkeep, m_tlast, m_sop, m_meta} !== st_vec) begin
                    errors++;
                    $display("FAIL hold_stable: got %h, required %h",
                             {m_tvalid, m_tdata, m_tkeep, m_tlast, m_sop, m_meta}, st_vec);
                end
            end
            stalled = m_tvalid && !m_tready;
            st_vec  = {m_tvalid, m_tdata, m_tkeep, m_tlast, m_sop, m_meta};
            if (m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data=%h keep=%h, required no beat", m_tdata, m_tkeep);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (((m_tdata & kmask(m_tkeep)) !== (mon_e.data & kmask(mon_e.keep))) ||
                        m_tkeep !== mon_e.keep || m_tlast !== mon_e.last ||
                        m_sop !== mon_e.sop || m_meta !== mon_e.meta) begin
                        errors++;
                        $display("FAIL out_beat: got d=%h k=%h l=%b s=%b meta=%h, required d=%h k=%h l=%b s=%b meta=%h",
                                 m_tdata, m_tkeep, m_tlast, m_sop, m_meta,
                                 mon_e.data, mon_e.keep, mon_e.last, mon_e.sop, mon_e.meta);
                    end
                end
            end
        end
    end

    initial begin
        bq_t p;
        bq_t part;
        bq_t rest;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_m_sop", 64'(m_sop), 64'd0);
        chk("rst_m_tdata", m_tdata, 64'd0);
        chk("rst_m_tkeep", 64'(m_tkeep), 64'd0);
        chk("rst_m_meta", m_meta, 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_ok_cnt", 64'(pkt_ok_cnt), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Basic layouts and end-of-packet boundaries.
        issue(build_pkt(1'b0, 64, 32'h1234_5678, 6'd0, 0));
        issue(build_pkt(1'b1, 61, 32'hCAFE_0001, 6'd9, 0));
        wait_drain();
        check_counts("good");
        issue(build_pkt(1'b0, 40, 32'h1, 6'd0, 1));
        issue(build_pkt(1'b0, 40, 32'h2, 6'd0, 2));
        issue(build_pkt(1'b0, 40, 32'h3, 6'd0, 3));
        wait_drain();
        check_counts("bad");
        issue(build_pkt(1'b0, 3, 32'hAAAA_0003, 6'd0, 0));
        issue(build_pkt(1'b0, 0, 32'hAAAA_0000, 6'd0, 0));
        issue(build_pkt(1'b1, 4, 32'hAAAA_0004, 6'd63, 0));
        issue(build_pkt(1'b1, 0, 32'hAAAA_0005, 6'd1, 0));
        issue(build_pkt(1'b0, 5, 32'hAAAA_0006, 6'd0, 0));
        wait_drain();
        check_counts("edge");

        // Long packet under random backpressure.
        rdy_rand = 1'b1;
        issue(build_pkt(1'b1, 1500, 32'h0BAD_F00D, 6'd17, 0));
        wait_drain();
        check_counts("long");

        // Random mix with input gaps and output backpressure.
        gap_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            int kind = $urandom_range(0, 9);
            int len  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom_range(1, 120);
            int cor  = (kind < 6) ? 0 : ((kind == 9) ? 10 : $urandom_range(1, 9));
            issue(build_pkt(1'($urandom_range(0, 1)), len, $urandom, 6'($urandom), cor));
        end
        wait_drain();
        check_counts("rand");

        // Reset while forwarding; the tail then arrives as a fresh packet.
        rdy_rand = 1'b0; gap_en = 1'b0; mon_en = 1'b0;
        p = build_pkt(1'b0, 200, 32'h5555_AAAA, 6'd0, 0);
        for (int i = 0; i < p.size(); i++)
            if (i < 80) part.push_back(p[i]); else rest.push_back(p[i]);
        send_bytes(part, 1'b0);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        end
        chk("midrst_ok_cnt", 64'(pkt_ok_cnt), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        mon_en = 1'b1; ok_exp = 0; drop_exp = 0;
        @(posedge clk); #1;
        issue(rest);
        issue(build_pkt(1'b1, 77, 32'h7777_0001, 6'd5, 0));
        wait_drain();
        check_counts("postrst");
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
